// File: rtl/alu_rr_arbiter.sv
// Two-requester round-robin front end for a shared ALU; responses return to their issuer in issue order.
// Latency: 1 cycle from issue to response; backpressure is by valid/ready with an in-flight cap of MAX_OUT.

// Small synchronous FIFO: wrap-around pointers, head entry presented from storage.
// Latency: push visible at head on the next edge; push while full is only taken with a same-cycle pop.
module alu_rr_fifo #(
    parameter int W     = 1,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         empty,
    output logic         full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop & ~empty;
    assign do_push  = push_vld & (~full | do_pop);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// ADD/SUB/AND/POPCNT unit with a registered result queue of DEPTH entries, {result, ovf, carry, zero}.
// Latency: 1 cycle; accepts a new operation while the queue has room or its head drains this cycle.
module alu_rr_alu #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] arg0,
    input  logic [WIDTH-1:0] arg1,
    input  logic [1:0]       oper,
    input  logic             in_vld,
    output logic             in_rdy,
    output logic [WIDTH+2:0] y,
    output logic             out_vld,
    input  logic             out_rdy
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             carry;
    logic             q_empty;
    logic             q_full;
    logic             q_pop;

    assign sum  = {1'b0, arg0} + {1'b0, arg1};
    assign diff = {1'b0, arg0} - {1'b0, arg1};

    // SUB reports borrow in the carry flag; overflow is two's-complement overflow.
    always_comb begin
        res   = '0;
        ovf   = 1'b0;
        carry = 1'b0;
        case (oper)
            2'b00: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (arg0[WIDTH-1] == arg1[WIDTH-1]) && (sum[WIDTH-1] != arg0[WIDTH-1]);
            end
            2'b01: begin
                res   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (arg0[WIDTH-1] != arg1[WIDTH-1]) && (diff[WIDTH-1] != arg0[WIDTH-1]);
            end
            2'b10: begin
                res = arg0 & arg1;
            end
            default: begin
                for (int i = 0; i < WIDTH; i++) begin
                    res = res + WIDTH'(arg0[i]);
                end
            end
        endcase
    end

    assign q_pop   = out_vld & out_rdy;
    assign in_rdy  = ~q_full | q_pop;
    assign out_vld = ~q_empty;

    alu_rr_fifo #(.W(WIDTH + 3), .DEPTH(DEPTH)) u_result_q (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (in_vld & in_rdy),
        .push_dat ({res, ovf, carry, (res == '0)}),
        .pop      (q_pop),
        .head_dat (y),
        .empty    (q_empty),
        .full     (q_full)
    );
endmodule

module alu_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int MAX_OUT = 2
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic [WIDTH-1:0] i_r0_arg0,
    input  logic [WIDTH-1:0] i_r0_arg1,
    input  logic [1:0]       i_r0_oper,
    input  logic             i_r0_VALID,
    output logic             o_r0_READY,
    output logic [WIDTH+2:0] o_r0_Y,
    output logic             o_r0_VALID,
    input  logic             i_r0_READY,
    input  logic [WIDTH-1:0] i_r1_arg0,
    input  logic [WIDTH-1:0] i_r1_arg1,
    input  logic [1:0]       i_r1_oper,
    input  logic             i_r1_VALID,
    output logic             o_r1_READY,
    output logic [WIDTH+2:0] o_r1_Y,
    output logic             o_r1_VALID,
    input  logic             i_r1_READY,
    output logic             o_busy
);
    logic             run;
    logic             rr_ptr;
    logic             lock_vld;
    logic             lock_id;
    logic             has_gnt;
    logic             gnt_id;
    logic             gnt_vld;
    logic             issue_ok;
    logic             issue;
    logic             alu_i_vld;
    logic             alu_i_rdy;
    logic             alu_o_vld;
    logic             alu_o_rdy;
    logic [WIDTH+2:0] alu_y;
    logic [WIDTH-1:0] mux_arg0;
    logic [WIDTH-1:0] mux_arg1;
    logic [1:0]       mux_oper;
    logic             tag_head;
    logic             tag_empty;
    logic             tag_full;
    logic             resp_pop;

    // A locked requester keeps the grant until its request is finally taken.
    always_comb begin
        has_gnt = 1'b0;
        gnt_id  = 1'b0;
        if (lock_vld) begin
            has_gnt = 1'b1;
            gnt_id  = lock_id;
        end else if (i_r0_VALID && i_r1_VALID) begin
            has_gnt = 1'b1;
            gnt_id  = rr_ptr;
        end else if (i_r0_VALID) begin
            has_gnt = 1'b1;
        end else if (i_r1_VALID) begin
            has_gnt = 1'b1;
            gnt_id  = 1'b1;
        end
    end

    assign gnt_vld  = has_gnt & (gnt_id ? i_r1_VALID : i_r0_VALID);
    assign mux_arg0 = gnt_id ? i_r1_arg0 : i_r0_arg0;
    assign mux_arg1 = gnt_id ? i_r1_arg1 : i_r0_arg1;
    assign mux_oper = gnt_id ? i_r1_oper : i_r0_oper;

    assign alu_o_rdy = ~tag_empty & (tag_head ? i_r1_READY : i_r0_READY);
    assign resp_pop  = alu_o_vld & alu_o_rdy;
    assign issue_ok  = ~tag_full | resp_pop;
    assign alu_i_vld = run & gnt_vld & issue_ok;
    assign issue     = alu_i_vld & alu_i_rdy;

    assign o_r0_READY = run & has_gnt & ~gnt_id & alu_i_rdy & issue_ok;
    assign o_r1_READY = run & has_gnt &  gnt_id & alu_i_rdy & issue_ok;
    assign o_r0_VALID = alu_o_vld & ~tag_empty & ~tag_head;
    assign o_r1_VALID = alu_o_vld & ~tag_empty &  tag_head;
    assign o_r0_Y     = alu_y;
    assign o_r1_Y     = alu_y;
    assign o_busy     = ~tag_empty;

    // run holds READY low during reset and for the first edge after release.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            run      <= 1'b0;
            rr_ptr   <= 1'b0;
            lock_vld <= 1'b0;
            lock_id  <= 1'b0;
        end else begin
            run <= 1'b1;
            if (issue) begin
                rr_ptr   <= ~gnt_id;
                lock_vld <= 1'b0;
            end else if (run && gnt_vld) begin
                lock_vld <= 1'b1;
                lock_id  <= gnt_id;
            end
        end
    end

    alu_rr_alu #(.WIDTH(WIDTH), .DEPTH(MAX_OUT)) u_alu (
        .clk     (i_CLK),
        .rst_n   (i_RSTn),
        .arg0    (mux_arg0),
        .arg1    (mux_arg1),
        .oper    (mux_oper),
        .in_vld  (alu_i_vld),
        .in_rdy  (alu_i_rdy),
        .y       (alu_y),
        .out_vld (alu_o_vld),
        .out_rdy (alu_o_rdy)
    );

    alu_rr_fifo #(.W(1), .DEPTH(MAX_OUT)) u_tag_q (
        .clk      (i_CLK),
        .rst_n    (i_RSTn),
        .push_vld (issue),
        .push_dat (gnt_id),
        .pop      (resp_pop),
        .head_dat (tag_head),
        .empty    (tag_empty),
        .full     (tag_full)
    );
endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios with literal expectations plus a long random run,
// all checked every cycle against a queue-based model of issue order and ALU arithmetic.
module tb_alu_rr_arbiter;
    localparam int WIDTH   = 8;
    localparam int MAX_OUT = 2;
    localparam int YW      = WIDTH + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [1:0]       op0, op1;
    logic             v0, v1, rr0, rr1;
    logic             rdy0, rdy1, vld0, vld1, busy;
    logic [YW-1:0]    y0, y1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          owner;
        logic [YW-1:0] y;
    } exp_t;
    exp_t mq[$];

    logic m_turn, m_lock, m_lk, m_run, m_g, m_has, m_gv, m_pop, m_room;
    logic m_e0, m_e1;
    exp_t m_ent;

    alu_rr_arbiter #(.WIDTH(WIDTH), .MAX_OUT(MAX_OUT)) dut (
        .i_CLK      (clk),
        .i_RSTn     (rst_n),
        .i_r0_arg0  (a0),
        .i_r0_arg1  (b0),
        .i_r0_oper  (op0),
        .i_r0_VALID (v0),
        .o_r0_READY (rdy0),
        .o_r0_Y     (y0),
        .o_r0_VALID (vld0),
        .i_r0_READY (rr0),
        .i_r1_arg0  (a1),
        .i_r1_arg1  (b1),
        .i_r1_oper  (op1),
        .i_r1_VALID (v1),
        .o_r1_READY (rdy1),
        .o_r1_Y     (y1),
        .o_r1_VALID (vld1),
        .i_r1_READY (rr1),
        .o_busy     (busy)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic from signed/unsigned integer ranges.
    function automatic logic [YW-1:0] alu_ref(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        int          sa, sb, r;
        int unsigned ua, ub;
        logic [WIDTH-1:0] res;
        logic c, o;
        sa = $signed(a);
        sb = $signed(b);
        ua = 32'(a);
        ub = 32'(b);
        c  = 1'b0;
        o  = 1'b0;
        case (op)
            2'd0: begin
                r   = sa + sb;
                res = WIDTH'(ua + ub);
                c   = (ua + ub) >= (32'd1 << WIDTH);
                o   = (r > 127) || (r < -128);
            end
            2'd1: begin
                r   = sa - sb;
                res = WIDTH'(ua - ub);
                c   = ua < ub;
                o   = (r > 127) || (r < -128);
            end
            2'd2: res = a & b;
            default: res = WIDTH'($countones(a));
        endcase
        return {res, o, c, (res == '0)};
    endfunction

    always @(negedge clk) begin : compare
        if (!rst_n) begin
            chk("reset_outputs", 32'({busy, vld1, vld0, rdy1, rdy0}), 32'd0);
            mq.delete();
            m_turn = 1'b0;
            m_lock = 1'b0;
            m_lk   = 1'b0;
            m_run  = 1'b0;
        end else begin
            m_has = 1'b1;
            m_g   = 1'b0;
            if (m_lock)         m_g = m_lk;
            else if (v0 && v1)  m_g = m_turn;
            else if (v0)        m_g = 1'b0;
            else if (v1)        m_g = 1'b1;
            else                m_has = 1'b0;
            m_gv   = m_has && (m_g ? v1 : v0);
            m_pop  = (mq.size() > 0) && (mq[0].owner ? rr1 : rr0);
            m_room = (mq.size() < MAX_OUT) || m_pop;
            m_e0   = m_run && m_has && !m_g && m_room;
            m_e1   = m_run && m_has &&  m_g && m_room;
            chk("req_ready", 32'({rdy1, rdy0}), 32'({m_e1, m_e0}));
            if (mq.size() > 0) begin
                chk("rsp_valid", 32'({vld1, vld0}), mq[0].owner ? 32'd2 : 32'd1);
                chk("rsp_data", 32'(mq[0].owner ? y1 : y0), 32'(mq[0].y));
            end else begin
                chk("rsp_valid_idle", 32'({vld1, vld0}), 32'd0);
            end
            chk("busy", 32'(busy), 32'(mq.size() != 0));
            chk("alu_valid_without_tag", 32'(dut.alu_o_vld && dut.tag_empty), 32'd0);
            if (m_pop) void'(mq.pop_front());
            if (m_run && m_gv) begin
                if (m_room) begin
                    m_ent.owner = m_g;
                    m_ent.y     = m_g ? alu_ref(op1, a1, b1) : alu_ref(op0, a0, b0);
                    mq.push_back(m_ent);
                    m_turn = ~m_g;
                    m_lock = 1'b0;
                end else begin
                    m_lock = 1'b1;
                    m_lk   = m_g;
                end
            end
            m_run = 1'b1;
        end
    end

    initial begin
        a0 = 8'h11; b0 = 8'h22; op0 = 2'd0; a1 = 8'h33; b1 = 8'h44; op1 = 2'd1;
        v0 = 1'b1; v1 = 1'b1; rr0 = 1'b1; rr1 = 1'b1;

        // Reset held with both requesters valid; r0 wins first after release.
        step();
        step();
        chk("rst_held_outputs", 32'({busy, vld1, vld0, rdy1, rdy0}), 32'd0);
        rst_n = 1'b1;
        step();
        chk("first_grant_r0", 32'({rdy1, rdy0}), 32'b01);

        // Single r0 ADD 7F+01 -> 80 with overflow set.
        v1 = 1'b0; a0 = 8'h7F; b0 = 8'h01; op0 = 2'd0;
        step();
        v0 = 1'b0;
        chk("add_rsp_valid", 32'({vld1, vld0}), 32'b01);
        chk("add_rsp_y", 32'(y0), 32'h404);
        step();
        chk("add_drained", 32'(busy), 32'd0);

        // Both requesters continuously valid: alternating grants starting with r1.
        v0 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a0 = 8'($urandom); b0 = 8'($urandom); op0 = 2'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom); op1 = 2'($urandom);
            #1;
            chk("alternate_grant", 32'({rdy1, rdy0}), (k % 2 == 0) ? 32'b10 : 32'b01);
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        step();
        step();

        // r1 SUB 5-5 stalls at the head; r0 AND queued behind it.
        v1 = 1'b1; a1 = 8'h05; b1 = 8'h05; op1 = 2'd1; rr1 = 1'b0; rr0 = 1'b1;
        step();
        v1 = 1'b0; v0 = 1'b1; a0 = 8'hF0; b0 = 8'h3C; op0 = 2'd2;
        step();
        for (int k = 0; k < 4; k++) begin
            chk("stall_head_r1", 32'({vld1, vld0}), 32'b10);
            chk("stall_y_zero", 32'(y1), 32'h001);
            chk("stall_no_issue", 32'({rdy1, rdy0}), 32'b00);
            chk("stall_busy", 32'(busy), 32'd1);
            step();
        end
        rr1 = 1'b1;
        #1;
        chk("issue_on_pop_at_max", 32'(rdy0), 32'd1);
        step();
        v0 = 1'b0;
        chk("r0_after_r1", 32'({vld1, vld0}), 32'b01);
        chk("and_rsp_y", 32'(y0), 32'h180);
        repeat (4) step();

        // Lock: r1 request stuck behind a full pipeline keeps the grant when r0 arrives.
        rr0 = 1'b0; rr1 = 1'b0; v1 = 1'b1; v0 = 1'b0;
        step();
        step();
        step();
        v0 = 1'b1;
        #1;
        chk("lock_full_no_ready", 32'({rdy1, rdy0}), 32'b00);
        rr1 = 1'b1;
        #1;
        chk("lock_hold_r1", 32'({rdy1, rdy0}), 32'b10);
        step();
        v0 = 1'b0; v1 = 1'b0; rr0 = 1'b1;
        repeat (4) step();

        // Async reset with two ops in flight.
        rr0 = 1'b0; rr1 = 1'b0; v0 = 1'b1;
        step();
        step();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_immediate", 32'({busy, vld1, vld0, rdy1, rdy0}), 32'd0);
        v0 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        v1 = 1'b1; a1 = 8'hFF; b1 = 8'h00; op1 = 2'd3; rr1 = 1'b1;
        step();
        v1 = 1'b0;
        chk("restart_popcnt_valid", 32'({vld1, vld0}), 32'b10);
        chk("restart_popcnt_y", 32'(y1), 32'h040);
        step();

        // Random traffic with occasional asynchronous resets.
        repeat (3000) begin
            v0  = ($urandom_range(0, 3) != 0);
            v1  = ($urandom_range(0, 3) != 0);
            rr0 = ($urandom_range(0, 3) != 0);
            rr1 = ($urandom_range(0, 2) != 0);
            a0 = 8'($urandom); b0 = 8'($urandom); op0 = 2'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom); op1 = 2'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
